wb_write_arbiter: RTL and testbench

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

---
 rtl/wb_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_write_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Arbitrates register-file writeback between the main pipeline and a
// multi-cycle unit. The pipeline always wins. Multi-cycle results that cannot
// be written immediately wait in a 2-entry FIFO. Any pipeline write to the
// same register invalidates them, because the pipeline result is newer.
// An age counter, and a full FIFO, raise StallReq. This asks the hazard unit
// for a writeback bubble so buffered results are not starved.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   PipeRegWrite/PipeWriteReg/PipeWriteData   main-pipeline writeback request
//   MulValid/MulWriteReg/MulWriteData         multi-cycle result offer
//   MulReady           offer accepted on this edge when MulValid=1
//   StallReq           combinational bubble request to the hazard unit
//   RegWrite/WriteRegister/WriteDataOut       registered register-file write
//   BufCount           number of buffered multi-cycle results (0..2)
module wb_write_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PipeRegWrite,
    input  logic [4:0]  PipeWriteReg,
    input  logic [31:0] PipeWriteData,
    input  logic        MulValid,
    input  logic [4:0]  MulWriteReg,
    input  logic [31:0] MulWriteData,
    output logic        MulReady,
    output logic        StallReq,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteDataOut,
    output logic [1:0]  BufCount
);

    // The FIFO is kept compacted, so entry 0 is always the head and entry 1
    // can be valid only when entry 0 is also valid.
    logic [1:0]       vld_q, vld_d;
    logic [1:0][4:0]  ereg_q, ereg_d;
    logic [1:0][31:0] edata_q, edata_d;
    logic [2:0]       age_q, age_d;
    logic             rw_q, rw_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic pipe_eff, pop, acc, acc_eff, bypass, head_gone;

    assign BufCount = vld_q[1] ? 2'd2 : (vld_q[0] ? 2'd1 : 2'd0);

    // Writes to register 0 are not real requests.
    assign pipe_eff = PipeRegWrite && (PipeWriteReg != 5'd0);
    assign pop      = !pipe_eff && vld_q[0];

    // A full FIFO can still accept an offer when its head drains this cycle.
    assign MulReady = !Reset && (!vld_q[1] || pop);
    assign acc      = MulValid && MulReady;
    // An accepted offer to r0, or to the register the pipeline writes now,
    // is consumed but never written.
    assign acc_eff  = acc && (MulWriteReg != 5'd0) &&
                      !(pipe_eff && (MulWriteReg == PipeWriteReg));
    assign bypass   = acc_eff && !pipe_eff && !vld_q[0];
    // The head leaves either by being written or by being invalidated.
    assign head_gone = pop || (pipe_eff && vld_q[0] && (ereg_q[0] == PipeWriteReg));

    assign StallReq = !Reset && (vld_q[1] || (vld_q[0] && (age_q == 3'd7)));

    assign RegWrite      = rw_q;
    assign WriteRegister = wreg_q;
    assign WriteDataOut  = wdata_q;

    // Write-port selection: pipeline, then FIFO head, then bypass.
    always_comb begin
        rw_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (pipe_eff) begin
            rw_d    = 1'b1;
            wreg_d  = PipeWriteReg;
            wdata_d = PipeWriteData;
        end else if (vld_q[0]) begin
            rw_d    = 1'b1;
            wreg_d  = ereg_q[0];
            wdata_d = edata_q[0];
        end else if (bypass) begin
            rw_d    = 1'b1;
            wreg_d  = MulWriteReg;
            wdata_d = MulWriteData;
        end
    end

    // FIFO next state: pop, invalidate, compact, then push.
    always_comb begin
        vld_d   = vld_q;
        ereg_d  = ereg_q;
        edata_d = edata_q;
        if (pop) begin
            vld_d      = {1'b0, vld_q[1]};
            ereg_d[0]  = ereg_q[1];
            edata_d[0] = edata_q[1];
        end
        if (pipe_eff) begin
            for (int i = 0; i < 2; i++) begin
                if (ereg_d[i] == PipeWriteReg) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (!vld_d[0] && vld_d[1]) begin
            vld_d      = 2'b01;
            ereg_d[0]  = ereg_d[1];
            edata_d[0] = edata_d[1];
        end
        if (acc_eff && !bypass) begin
            if (!vld_d[0]) begin
                vld_d[0]   = 1'b1;
                ereg_d[0]  = MulWriteReg;
                edata_d[0] = MulWriteData;
            end else begin
                vld_d[1]   = 1'b1;
                ereg_d[1]  = MulWriteReg;
                edata_d[1] = MulWriteData;
            end
        end

        // The age restarts whenever a different entry becomes the head.
        if ((vld_d == 2'b00) || !vld_q[0] || head_gone) begin
            age_d = 3'd0;
        end else if (age_q != 3'd7) begin
            age_d = age_q + 3'd1;
        end else begin
            age_d = age_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_q   <= 2'b00;
            age_q   <= 3'd0;
            rw_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            vld_q   <= vld_d;
            age_q   <= age_d;
            rw_q    <= rw_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry payloads are qualified by vld_q, so they need no reset.
    always_ff @(posedge Clk) begin
        ereg_q  <= ereg_d;
        edata_q <= edata_d;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PipeRegWrite;
    logic [4:0]  PipeWriteReg;
    logic [31:0] PipeWriteData;
    logic        MulValid;
    logic [4:0]  MulWriteReg;
    logic [31:0] MulWriteData;
    logic        MulReady;
    logic        StallReq;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteDataOut;
    logic [1:0]  BufCount;

    wb_write_arbiter dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .PipeRegWrite  (PipeRegWrite),
        .PipeWriteReg  (PipeWriteReg),
        .PipeWriteData (PipeWriteData),
        .MulValid      (MulValid),
        .MulWriteReg   (MulWriteReg),
        .MulWriteData  (MulWriteData),
        .MulReady      (MulReady),
        .StallReq      (StallReq),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteDataOut  (WriteDataOut),
        .BufCount      (BufCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        prw;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic        e_mr;   // MulReady before the edge
        logic        e_st;   // StallReq before the edge
        logic        e_rw;   // after the edge
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic rst, input logic prw, input logic [4:0] preg,
                                input logic [31:0] pdata, input logic mv, input logic [4:0] mreg,
                                input logic [31:0] mdata, input logic e_mr, input logic e_st,
                                input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd,
                                input logic [1:0] e_cnt);
        vec_t v;
        v.rst = rst; v.prw = prw; v.preg = preg; v.pdata = pdata;
        v.mv = mv; v.mreg = mreg; v.mdata = mdata;
        v.e_mr = e_mr; v.e_st = e_st; v.e_rw = e_rw; v.e_wr = e_wr;
        v.e_wd = e_wd; v.e_cnt = e_cnt;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic prw, input logic [4:0] preg,
                         input logic [31:0] pdata, input logic mv, input logic [4:0] mreg,
                         input logic [31:0] mdata);
        Reset = rst; PipeRegWrite = prw; PipeWriteReg = preg; PipeWriteData = pdata;
        MulValid = mv; MulWriteReg = mreg; MulWriteData = mdata;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge Clk);
        drive(v.rst, v.prw, v.preg, v.pdata, v.mv, v.mreg, v.mdata);
        #1;
        check("MulReady", idx, {31'd0, MulReady}, {31'd0, v.e_mr});
        check("StallReq", idx, {31'd0, StallReq}, {31'd0, v.e_st});
        @(posedge Clk);
        #1;
        check("RegWrite", idx, {31'd0, RegWrite}, {31'd0, v.e_rw});
        check("WriteRegister", idx, {27'd0, WriteRegister}, {27'd0, v.e_wr});
        check("WriteDataOut", idx, WriteDataOut, v.e_wd);
        check("BufCount", idx, {30'd0, BufCount}, {30'd0, v.e_cnt});
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        //   rst prw preg pdata        mv mreg mdata        mr st  rw wr  wd           cnt
        // reset
        add(1, 0, 0,  32'h0,       0, 0,  32'h0,       0, 0,  0, 0,  32'h0,       0);
        // pipe write, latency 1
        add(0, 1, 5,  32'h1234,    0, 0,  32'h0,       1, 0,  1, 5,  32'h1234,    0);
        // bypass of a Mul result into an empty FIFO
        add(0, 0, 0,  32'h0,       1, 9,  32'hDEAD,    1, 0,  1, 9,  32'hDEAD,    0);
        // idle: no write, outputs hold
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 9,  32'hDEAD,    0);
        // register 0 is no request, for pipe and Mul
        add(0, 1, 0,  32'h5555,    0, 0,  32'h0,       1, 0,  0, 9,  32'hDEAD,    0);
        add(0, 0, 0,  32'h0,       1, 0,  32'h6666,    1, 0,  0, 9,  32'hDEAD,    0);
        // pipe every cycle, Mul offers reg 3 then reg 4
        add(0, 1, 1,  32'h11,      1, 3,  32'h33,      1, 0,  1, 1,  32'h11,      1);
        add(0, 1, 2,  32'h22,      1, 4,  32'h44,      1, 0,  1, 2,  32'h22,      2);
        add(0, 1, 6,  32'h66,      1, 8,  32'h88,      0, 1,  1, 6,  32'h66,      2);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 1,  1, 3,  32'h33,      1);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  1, 4,  32'h44,      0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 4,  32'h44,      0);
        // buffered reg 7 invalidated by a pipe write to reg 7
        add(0, 1, 1,  32'h100,     1, 7,  32'h77,      1, 0,  1, 1,  32'h100,     1);
        add(0, 1, 7,  32'h777,     0, 0,  32'h0,       1, 0,  1, 7,  32'h777,     0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 7,  32'h777,     0);
        // same-cycle Mul offer to the pipe's register is dropped
        add(0, 1, 10, 32'hA,       1, 10, 32'hB,       1, 0,  1, 10, 32'hA,       0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 10, 32'hA,       0);
        // one entry blocked by 7 pipe writes, then a bubble drains it
        add(0, 1, 1,  32'h1,       1, 12, 32'hC,       1, 0,  1, 1,  32'h1,       1);
        for (int i = 0; i < 7; i++)
            add(0, 1, 2, 32'h20 + i, 0, 0, 32'h0,      1, 0,  1, 2,  32'h20 + i,  1);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 1,  1, 12, 32'hC,       0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 12, 32'hC,       0);
        // simultaneous push and pop keeps order and count
        add(0, 1, 1,  32'h1,       1, 13, 32'hD13,     1, 0,  1, 1,  32'h1,       1);
        add(0, 0, 0,  32'h0,       1, 14, 32'hD14,     1, 0,  1, 13, 32'hD13,     1);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  1, 14, 32'hD14,     0);
        // reset with a full FIFO discards everything
        add(0, 1, 1,  32'h1,       1, 15, 32'hF15,     1, 0,  1, 1,  32'h1,       1);
        add(0, 1, 2,  32'h2,       1, 16, 32'hF16,     1, 0,  1, 2,  32'h2,       2);
        add(1, 0, 0,  32'h0,       1, 17, 32'hF17,     0, 0,  0, 0,  32'h0,       0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 0,  32'h0,       0);
        add(0, 0, 0,  32'h0,       0, 0,  32'h0,       1, 0,  0, 0,  32'h0,       0);

        for (int i = 0; i < vq.size(); i++)
            apply_vec(vq[i], i);

        // Age saturation: one entry held back for 10 edges; StallReq stays up
        // from the seventh wait onward, then a bubble drains the entry.
        @(negedge Clk);
        drive(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hABC);
        @(posedge Clk);
        #1;
        check("seq_cnt", 0, {30'd0, BufCount}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            drive(1'b0, 1'b1, 5'd2, 32'h300 + i, 1'b0, 5'd0, 32'h0);
            #1;
            check("seq_stall", i, {31'd0, StallReq}, (i >= 7) ? 32'd1 : 32'd0);
            @(posedge Clk);
            #1;
            check("seq_wd", i, WriteDataOut, 32'h300 + i);
        end
        @(negedge Clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("seq_stall_sat", 0, {31'd0, StallReq}, 32'd1);
        @(posedge Clk);
        #1;
        check("seq_drain_wr", 0, {27'd0, WriteRegister}, 32'd20);
        check("seq_drain_wd", 0, WriteDataOut, 32'hABC);
        check("seq_drain_cnt", 0, {30'd0, BufCount}, 32'd0);
        @(negedge Clk);
        #1;
        check("seq_stall_clr", 0, {31'd0, StallReq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
